// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the keyboard controller.
// Scan-code prefixes, event record, controller FSM states and the
// helper that packs an event into the CPU read word.
package kbd_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } kbd_ctrl_state_t;

  // Layout: {valid[31], zeros[30:10], ext[9], brk[8], code[7:0]}
  function automatic logic [31:0] evt_to_word(input kbd_evt_t evt);
    return {1'b1, 21'b0, evt.ext, evt.brk, evt.code};
  endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo: small synchronous FIFO of key events.
// The head entry is read combinationally so the CPU word is always current.
// Push and pop in the same cycle both take effect, including when full.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          push,
  input  logic          pop,
  input  kbd_evt_t      din,
  output kbd_evt_t      dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  kbd_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;
  logic            do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // A pop on an empty FIFO is ignored; a push on a full FIFO is only
  // accepted when a pop frees the head slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: sequences the ps2_kbd read handshake, folds E0/F0 prefixes
// into key events and buffers them for a single-word CPU read.
// Optional typematic repeat filter: define KBD_CTRL_TYPEMATIC_FILTER_EN.
module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [7:0]    kb_data,
  input  logic          kb_ready,
  input  logic          kb_overflow,
  output logic          kb_rdn,
  input  logic          cpu_rd,
  output logic [31:0]   cpu_rdata,
  input  logic          ovf_clr,
  output logic [AW:0]   evt_count,
  output logic          ovf
);

  kbd_ctrl_state_t state_q, state_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic            ovf_q, ovf_d;
  logic            push_raw;
  logic            push;
  logic            fifo_full, fifo_empty;
  kbd_evt_t        evt_in, fifo_dout;

  assign evt_in = '{ext: ext_q, brk: brk_q, code: kb_data};

  // Handshake FSM and prefix folding; a byte is taken only at the end of POP.
  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    push_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (kb_ready && !fifo_full) state_d = POP;
      end
      POP: begin
        state_d = GAP;
        if (kb_data == SC_EXT) begin
          ext_d = 1'b1;
        end else if (kb_data == SC_BRK) begin
          brk_d = 1'b1;
        end else begin
          push_raw = 1'b1;
          ext_d    = 1'b0;
          brk_d    = 1'b0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and prefix flags.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
    end
  end

  // Decoded from the state register, so reset forces it high immediately.
  assign kb_rdn = (state_q != POP);

`ifdef KBD_CTRL_TYPEMATIC_FILTER_EN
  logic [8:0] last_make_q, last_make_d;
  logic       held_q, held_d;
  logic [8:0] evt_key;
  logic       drop;

  assign evt_key = {ext_q, kb_data};
  assign drop    = !brk_q && held_q && (evt_key == last_make_q);
  assign push    = push_raw && !drop;

  // Track the last key pressed; its break releases the repeat suppression.
  always_comb begin
    last_make_d = last_make_q;
    held_d      = held_q;
    if (push_raw) begin
      if (brk_q) begin
        if (evt_key == last_make_q) held_d = 1'b0;
      end else if (!drop) begin
        last_make_d = evt_key;
        held_d      = 1'b1;
      end
    end
  end

  // Repeat-filter registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_make_q <= '0;
      held_q      <= 1'b0;
    end else begin
      last_make_q <= last_make_d;
      held_q      <= held_d;
    end
  end
`else
  assign push = push_raw;
`endif

  kbd_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (cpu_rd),
    .din   (evt_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (evt_count)
  );

  assign cpu_rdata = fifo_empty ? 32'h0 : evt_to_word(fifo_dout);

  // Sticky overflow: a new overflow beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (kb_overflow)  ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// tb_kbd_ctrl: directed test of kbd_ctrl against a simple ps2_kbd byte source.
module tb_kbd_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic [7:0]    kb_data = 8'h00;
  logic          kb_ready = 1'b0;
  logic          kb_overflow = 1'b0;
  logic          kb_rdn;
  logic          cpu_rd = 1'b0;
  logic [31:0]   cpu_rdata;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   evt_count;
  logic          ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  src_q [$];
  logic [31:0] exp_evt [$];
  bit          pend = 1'b0;
  int          pulses = 0;
  int          viol = 0;
  int          cyc = 0;
  int          last_low = -100;

  always #5 clk = ~clk;

  kbd_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .kb_overflow (kb_overflow),
    .kb_rdn      (kb_rdn),
    .cpu_rd      (cpu_rd),
    .cpu_rdata   (cpu_rdata),
    .ovf_clr     (ovf_clr),
    .evt_count   (evt_count),
    .ovf         (ovf)
  );

  // Byte source: a low kb_rdn in one cycle removes the head byte in the next.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (!clrn) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (src_q.size() > 0) src_q.delete(0);
        pend = 1'b0;
      end
      if (kb_rdn == 1'b0) begin
        pend = 1'b1;
        pulses++;
        if (cyc - last_low < 3) viol++;
        last_low = cyc;
      end
    end
    kb_ready = (src_q.size() > 0);
    kb_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %08h", tag, got);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_count(input int exp, input int budget, input string tag);
    int k;
    k = 0;
    while (evt_count != exp[AW:0] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(evt_count), exp);
  endtask

  task automatic cpu_pop();
    @(negedge clk) cpu_rd = 1'b1;
    @(negedge clk) cpu_rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b0;
    src_q.delete();
    @(negedge clk) clrn = 1'b1;
  endtask

  initial begin
    int p0;
    int k;
    logic [7:0] fbytes [6];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdn", 32'(kb_rdn), 1);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_cnt", 32'(evt_count), 0);
    check("rst_rdata", cpu_rdata, 32'h0);
    clrn = 1'b1;
    @(negedge clk);

    // Single make code and its latency from kb_ready
    src_q.push_back(8'h1C);
    k = 0;
    while (kb_ready !== 1'b1 && k < 5) begin @(negedge clk); k++; end
    check("src_ready", 32'(kb_ready), 1);
    check("lat0_cnt", 32'(evt_count), 0);
    @(negedge clk);
    check("lat1_rdn", 32'(kb_rdn), 0);
    check("lat1_cnt", 32'(evt_count), 0);
    @(negedge clk);
    check("1c_rdata", cpu_rdata, 32'h8000001C);
    check("1c_cnt", 32'(evt_count), 1);
    cpu_pop();
    check("1c_pop_rdata", cpu_rdata, 32'h0);
    check("1c_pop_cnt", 32'(evt_count), 0);
    cpu_pop();
    check("empty_rd_cnt", 32'(evt_count), 0);
    check("empty_rd_rdata", cpu_rdata, 32'h0);

    // Extended break: E0 F0 75 folds into one event
    wait_cycles(3);
    p0 = pulses;
    src_q.push_back(8'hE0);
    src_q.push_back(8'hF0);
    src_q.push_back(8'h75);
    wait_count(1, 40, "pfx_cnt");
    wait_cycles(3);
    check("pfx_rdata", cpu_rdata, 32'h80000375);
    check("pfx_pulses", 32'(pulses - p0), 3);
    cpu_pop();
    check("pfx_pop_cnt", 32'(evt_count), 0);

    // Fill to DEPTH with a ninth byte pending: backpressure, then refill
    wait_cycles(3);
    p0 = pulses;
    for (int i = 0; i < 9; i++) src_q.push_back(8'h10 + 8'(i));
    wait_count(8, 60, "full_cnt");
    wait_cycles(10);
    check("full_rdn", 32'(kb_rdn), 1);
    check("full_pulses", 32'(pulses - p0), 8);
    check("full_cnt_hold", 32'(evt_count), 8);
    check("full_head", cpu_rdata, 32'h80000010);
    cpu_pop();
    wait_cycles(10);
    check("refill_pulses", 32'(pulses - p0), 9);
    check("refill_cnt", 32'(evt_count), 8);
    check("refill_head", cpu_rdata, 32'h80000011);
    for (int i = 0; i < 8; i++) cpu_pop();
    check("drain_cnt", 32'(evt_count), 0);

    // One entry buffered; CPU pop lands on the POP cycle of byte 2A
    wait_cycles(3);
    src_q.push_back(8'h21);
    wait_count(1, 20, "one_cnt");
    wait_cycles(3);
    src_q.push_back(8'h2A);
    k = 0;
    while (kb_rdn !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    check("sim_pop_seen", 32'(kb_rdn), 0);
    cpu_rd = 1'b1;
    @(negedge clk) cpu_rd = 1'b0;
    check("sim_cnt", 32'(evt_count), 1);
    check("sim_head", cpu_rdata, 32'h8000002A);
    cpu_pop();
    check("sim_pop_cnt", 32'(evt_count), 0);

    // Sticky overflow
    @(negedge clk) kb_overflow = 1'b1;
    @(negedge clk) kb_overflow = 1'b0;
    check("ovf_set", 32'(ovf), 1);
    kb_overflow = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf), 1);
    ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);

    // Typematic sequence 1C 1C 1C F0 1C 1C
    do_reset();
    fbytes = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    foreach (fbytes[i]) src_q.push_back(fbytes[i]);
`ifdef KBD_CTRL_TYPEMATIC_FILTER_EN
    exp_evt = '{32'h8000001C, 32'h8000011C, 32'h8000001C};
`else
    exp_evt = '{32'h8000001C, 32'h8000001C, 32'h8000001C, 32'h8000011C, 32'h8000001C};
`endif
    wait_cycles(40);
    check("typ_cnt", 32'(evt_count), exp_evt.size());
    foreach (exp_evt[i]) begin
      check($sformatf("typ_evt%0d", i), cpu_rdata, exp_evt[i]);
      cpu_pop();
    end
    check("typ_drain_cnt", 32'(evt_count), 0);

    // Reset after a break prefix discards it
    do_reset();
    src_q.push_back(8'hF0);
    wait_cycles(8);
    @(negedge clk) clrn = 1'b0;
    #1;
    check("mid_rst_cnt", 32'(evt_count), 0);
    check("mid_rst_rdn", 32'(kb_rdn), 1);
    @(negedge clk) clrn = 1'b1;
    src_q.push_back(8'h1C);
    wait_count(1, 20, "post_rst_cnt");
    check("post_rst_head", cpu_rdata, 32'h8000001C);

    check("rdn_spacing_viol", 32'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
